// File: rtl/mod_leg_servo_pwm_pkg.sv
// Shared definitions for the leg-servo PWM channels and the gait machines.
// Holds the gait state indices, slew FSM encoding and default timing constants.
// Also provides the per-frame slew step used when moving the pulse width.
package mod_leg_servo_pwm_pkg;

  // Bit positions of the one-hot gait state vector
  localparam int ST0        = 0;
  localparam int ST1        = 1;
  localparam int ST2        = 2;
  localparam int NUM_STATES = 3;

  // Slew FSM: HOLD when the pulse width sits on target, RAMP while moving
  typedef enum logic {
    HOLD = 1'b0,
    RAMP = 1'b1
  } slew_state_t;

  // Default timing for a 50 MHz clock driving a standard hobby servo
  localparam int DEF_CLK_DIV   = 50;
  localparam int DEF_PERIOD_US = 20000;
  localparam int DEF_PW0_US    = 1000;
  localparam int DEF_PW1_US    = 1500;
  localparam int DEF_PW2_US    = 2000;
  localparam int DEF_STEP_US   = 10;

  // Move cur toward tgt by at most step, never past tgt
  function automatic int unsigned slew_step(input int unsigned cur,
                                            input int unsigned tgt,
                                            input int unsigned step);
    int unsigned res;
    if (tgt > cur) begin
      res = ((tgt - cur) > step) ? (cur + step) : tgt;
    end else begin
      res = ((cur - tgt) > step) ? (cur - step) : tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_leg_servo_pwm_frame_timer.sv
// Microsecond prescaler plus PWM frame counter, reusable by any PWM channel.
// us_tick is combinational from the prescaler; frame_start is registered so it
// lines up with the cycle both counters read zero (never the cycle after reset).
module mod_us_frame_timer #(
  parameter int CLK_DIV   = 50,
  parameter int PERIOD_US = 20000,
  parameter int FW        = $clog2(PERIOD_US)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          us_tick,
  output logic [FW-1:0] frame_cnt,
  output logic          frame_start
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PS_W-1:0] prescaler;
  logic            frame_last;

  assign us_tick    = (prescaler == PS_W'(CLK_DIV - 1));
  assign frame_last = (frame_cnt == FW'(PERIOD_US - 1));

  // Prescaler and frame counter; frame_start flags the wrap back to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= us_tick && frame_last;
      if (us_tick) begin
        prescaler <= '0;
        frame_cnt <= frame_last ? '0 : frame_cnt + FW'(1);
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
    end
  end

endmodule

// File: rtl/mod_leg_servo_pwm.sv
// Converts a one-hot gait state into a slew-limited hobby-servo PWM pulse.
// pwm is registered (one clk behind the frame counter); widths change only at
// frame boundaries, so a pulse in progress is never truncated or stretched.
module mod_leg_servo_pwm
  import mod_leg_servo_pwm_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int PERIOD_US = DEF_PERIOD_US,
  parameter int PW0_US    = DEF_PW0_US,
  parameter int PW1_US    = DEF_PW1_US,
  parameter int PW2_US    = DEF_PW2_US,
  parameter int STEP_US   = DEF_STEP_US
) (
  input  logic clk,
  input  logic rst,
  input  logic state0,
  input  logic state1,
  input  logic state2,
  output logic pwm,
  output logic frame_start,
  output logic at_target,
  output logic fault
);

  localparam int W = $clog2(PERIOD_US);

  logic [W-1:0]            frame_cnt;
  logic                    us_tick_unused;
  logic [NUM_STATES-1:0]   st_vec;
  logic                    onehot;
  logic [W-1:0]            tgt_dec;
  logic [W-1:0]            pw_next;
  logic [W-1:0]            pw_eff;
  logic [W-1:0]            cur_pw;
  logic [W-1:0]            target;
  slew_state_t             slew_st;

  // The microsecond tick is only needed inside the timer for this channel
  mod_us_frame_timer #(
    .CLK_DIV  (CLK_DIV),
    .PERIOD_US(PERIOD_US),
    .FW       (W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .us_tick    (us_tick_unused),
    .frame_cnt  (frame_cnt),
    .frame_start(frame_start)
  );

  // Decode the gait state; anything not one-hot keeps the previous target
  always_comb begin
    st_vec      = '0;
    st_vec[ST0] = state0;
    st_vec[ST1] = state1;
    st_vec[ST2] = state2;
    onehot      = 1'b1;
    tgt_dec     = target;
    if (st_vec == NUM_STATES'(1 << ST0)) begin
      tgt_dec = W'(PW0_US);
    end else if (st_vec == NUM_STATES'(1 << ST1)) begin
      tgt_dec = W'(PW1_US);
    end else if (st_vec == NUM_STATES'(1 << ST2)) begin
      tgt_dec = W'(PW2_US);
    end else begin
      onehot  = 1'b0;
    end
  end

  // Width for the coming frame; on the boundary cycle the stepped value is
  // used immediately so the new frame's very first compare is already correct
  always_comb begin
    pw_next = W'(slew_step(32'(cur_pw), 32'(tgt_dec), 32'(STEP_US)));
    pw_eff  = frame_start ? pw_next : cur_pw;
  end

  // Slew FSM: pulse width only moves on frame boundaries, toward the target
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pw    <= W'(PW0_US);
      target    <= W'(PW0_US);
      slew_st   <= HOLD;
      at_target <= 1'b1;
    end else begin
      target <= tgt_dec;
      if (frame_start) begin
        cur_pw <= pw_next;
      end
      case (slew_st)
        HOLD: begin
          if (pw_eff != tgt_dec) begin
            slew_st   <= RAMP;
            at_target <= 1'b0;
          end
        end
        RAMP: begin
          if (pw_eff == tgt_dec) begin
            slew_st   <= HOLD;
            at_target <= 1'b1;
          end
        end
        default: begin
          slew_st   <= HOLD;
          at_target <= 1'b1;
        end
      endcase
    end
  end

  // PWM output register; widths at or beyond the period hold pwm high
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (frame_cnt < pw_eff);
    end
  end

  // Sticky fault on any all-zero or multi-hot gait state
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (!onehot) begin
      fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mod_leg_servo_pwm.sv
// Self-checking bench for mod_leg_servo_pwm with small timing parameters.
// Directed frame table, hand-written corner sequences, then random frames
// checked against a per-frame arithmetic model of the slew behaviour.
module tb_mod_leg_servo_pwm;

  localparam int CLK_DIV    = 2;
  localparam int PERIOD_US  = 50;
  localparam int PW0        = 10;
  localparam int PW1        = 15;
  localparam int PW2        = 25;
  localparam int STEP       = 4;
  localparam int FRAME_CLKS = CLK_DIV * PERIOD_US;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] st  = 3'b001;
  logic       pwm, frame_start, at_target, fault;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] inp;
    int         hi;
    bit         at;
    bit         flt;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  mod_leg_servo_pwm #(
    .CLK_DIV  (CLK_DIV),
    .PERIOD_US(PERIOD_US),
    .PW0_US   (PW0),
    .PW1_US   (PW1),
    .PW2_US   (PW2),
    .STEP_US  (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state0     (st[0]),
    .state1     (st[1]),
    .state2     (st[2]),
    .pwm        (pwm),
    .frame_start(frame_start),
    .at_target  (at_target),
    .fault      (fault)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: target width for a state pattern; non-one-hot keeps the old one
  function automatic int ref_target(input logic [2:0] s, input int held);
    case (s)
      3'b001:  return PW0;
      3'b010:  return PW1;
      3'b100:  return PW2;
      default: return held;
    endcase
  endfunction

  function automatic bit ref_invalid(input logic [2:0] s);
    return !(s == 3'b001 || s == 3'b010 || s == 3'b100);
  endfunction

  // Reference: one frame-boundary slew step toward the target
  function automatic int ref_step(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d > STEP)  d = STEP;
    if (d < -STEP) d = -STEP;
    return cur + d;
  endfunction

  // Called at the negedge of the reset-release cycle: checks reset outputs,
  // then counts pwm-high clks up to the first frame_start
  task automatic after_reset(input string tag, input int exp_hi);
    int hi;
    int k;
    check({tag, "_rst_pwm"}, pwm, 0);
    check({tag, "_rst_frame_start"}, frame_start, 0);
    check({tag, "_rst_at_target"}, at_target, 1);
    check({tag, "_rst_fault"}, fault, 0);
    hi = 0;
    k  = 0;
    for (int i = 1; i <= 3 * FRAME_CLKS; i++) begin
      @(negedge clk);
      hi += int'(pwm);
      if (frame_start) begin
        k = i;
        break;
      end
    end
    check({tag, "_first_frame_len"}, k, FRAME_CLKS);
    check({tag, "_first_frame_hi"}, hi, exp_hi);
  endtask

  // Starts at the negedge of a frame_start cycle, ends at the next one.
  // Optionally changes the inputs mid-frame (for one clk if mid_pulse).
  task automatic measure_frame(input bit mid_en, input logic [2:0] mid_in,
                               input bit mid_pulse, output int hi, output int glitch);
    logic [2:0] saved;
    bit         seen_low;
    bit         found;
    hi       = 0;
    glitch   = 0;
    seen_low = 1'b0;
    saved    = st;
    for (int i = 1; i <= FRAME_CLKS; i++) begin
      @(negedge clk);
      if (mid_en && i == FRAME_CLKS / 2) st = mid_in;
      if (mid_en && mid_pulse && i == FRAME_CLKS / 2 + 1) st = saved;
      hi += int'(pwm);
      if (pwm && seen_low) glitch = 1;
      if (!pwm) seen_low = 1'b1;
    end
    check("frame_start_period", frame_start, 1);
    if (!frame_start) begin
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
        @(negedge clk);
        if (frame_start) begin
          found = 1'b1;
          break;
        end
      end
      check("frame_start_resync", int'(found), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, gl;
    int cur, tgt, exp_hi;
    bit flt;
    logic [2:0] pat, mid;
    bit mid_en;
    logic [2:0] bad [5];

    // Directed frames: inputs applied on the frame_start cycle itself
    tbl[0]  = '{3'b100, 28, 1'b0, 1'b0};  // 10 -> 14
    tbl[1]  = '{3'b100, 36, 1'b0, 1'b0};  // -> 18
    tbl[2]  = '{3'b010, 30, 1'b1, 1'b0};  // -> 15, step of 3, no overshoot
    tbl[3]  = '{3'b010, 30, 1'b1, 1'b0};  // hold 15
    tbl[4]  = '{3'b100, 38, 1'b0, 1'b0};  // -> 19
    tbl[5]  = '{3'b100, 46, 1'b0, 1'b0};  // -> 23
    tbl[6]  = '{3'b100, 50, 1'b1, 1'b0};  // -> 25
    tbl[7]  = '{3'b001, 42, 1'b0, 1'b0};  // reverse: -> 21
    tbl[8]  = '{3'b001, 34, 1'b0, 1'b0};  // -> 17
    tbl[9]  = '{3'b001, 26, 1'b0, 1'b0};  // -> 13
    tbl[10] = '{3'b001, 20, 1'b1, 1'b0};  // -> 10
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;

    // Reset with state0, first frame at PW0
    st  = 3'b001;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    after_reset("init", 2 * PW0);
    check("init_at_target", at_target, 1);

    for (int v = 0; v < 11; v++) begin
      st = tbl[v].inp;
      measure_frame(1'b0, 3'b000, 1'b0, hi, gl);
      check($sformatf("tbl%0d_hi", v), hi, tbl[v].hi);
      check($sformatf("tbl%0d_at_target", v), at_target, int'(tbl[v].at));
      check($sformatf("tbl%0d_fault", v), fault, int'(tbl[v].flt));
      check($sformatf("tbl%0d_glitch", v), gl, 0);
    end

    // Mid-frame retarget: current pulse untouched, ramp starts next boundary
    measure_frame(1'b1, 3'b100, 1'b0, hi, gl);
    check("mid_hi", hi, 20);
    check("mid_at_target", at_target, 0);
    measure_frame(1'b0, 3'b000, 1'b0, hi, gl);
    check("mid_next_hi", hi, 28);
    st = 3'b001;
    measure_frame(1'b0, 3'b000, 1'b0, hi, gl);
    check("mid_back_hi", hi, 20);
    check("mid_back_at_target", at_target, 1);

    // One-clk multi-hot input: sticky fault, target and widths unaffected
    measure_frame(1'b1, 3'b101, 1'b1, hi, gl);
    check("fault_set", fault, 1);
    check("fault_hi", hi, 20);
    check("fault_at_target", at_target, 1);
    measure_frame(1'b0, 3'b000, 1'b0, hi, gl);
    check("fault_sticky", fault, 1);
    check("fault_next_hi", hi, 20);

    // Reset mid-pulse during a ramp aborts everything and clears the fault
    st = 3'b100;
    measure_frame(1'b0, 3'b000, 1'b0, hi, gl);
    check("ramp_hi", hi, 28);
    repeat (10) @(negedge clk);
    check("ramp_mid_pulse_pwm", pwm, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    st  = 3'b001;
    after_reset("midrst", 2 * PW0);
    check("midrst_at_target", at_target, 1);

    // Random frames against the per-frame model
    cur = PW0;
    tgt = PW0;
    flt = 1'b0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) pat = bad[$urandom_range(0, 4)];
      else pat = 3'(3'b001 << $urandom_range(0, 2));
      mid_en = ($urandom_range(0, 3) == 0);
      mid    = 3'(3'b001 << $urandom_range(0, 2));
      st = pat;
      tgt = ref_target(pat, tgt);
      if (ref_invalid(pat)) flt = 1'b1;
      cur = ref_step(cur, tgt);
      exp_hi = ((cur < PERIOD_US) ? cur : PERIOD_US) * CLK_DIV;
      if (mid_en) tgt = ref_target(mid, tgt);
      measure_frame(mid_en, mid, 1'b0, hi, gl);
      check($sformatf("rnd%0d_hi", f), hi, exp_hi);
      check($sformatf("rnd%0d_at_target", f), at_target, int'(cur == tgt));
      check($sformatf("rnd%0d_fault", f), fault, int'(flt));
      check($sformatf("rnd%0d_glitch", f), gl, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_leg_servo_pwm.md
Name: mod_leg_servo_pwm

Overview:
- Downstream consumer of the tri-state gait machine: converts its one-hot leg state (state0/1/2) into a hobby-servo PWM waveform for one spider leg joint.
- Each state maps to a programmable pulse width; changes are slew-limited per PWM frame to avoid mechanical jerk.
- One instance per leg joint; all instances share clk/rst with the gait machines.

Parameters:
- CLK_DIV, 50, clk cycles per 1 us tick (50 MHz clock).
- PERIOD_US, 20000, PWM frame length in us.
- PW0_US, 1000, pulse width for state0 (us).
- PW1_US, 1500, pulse width for state1 (us).
- PW2_US, 2000, pulse width for state2 (us).
- STEP_US, 10, maximum pulse-width change per frame (us); STEP_US >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- state0  input  1  gait state 0 (one-hot with state1/state2).
- state1  input  1  gait state 1.
- state2  input  1  gait state 2.
- pwm  output  1  servo drive, registered.
- frame_start  output  1  one-cycle pulse on the first clk of each frame.
- at_target  output  1  1 when current pulse width equals target.
- fault  output  1  sticky; set on a non-one-hot state input.

Behaviour:
- Reset values (cycle after rst sampled high): prescaler=0, frame_cnt=0, cur_pw=PW0_US, target=PW0_US, pwm=0, frame_start=0, at_target=1, fault=0. Reset mid-ramp or mid-pulse aborts immediately; no partial pulse completes.
- Prescaler counts 0..CLK_DIV-1; us_tick asserted when it equals CLK_DIV-1, then wraps to 0.
- frame_cnt counts 0..PERIOD_US-1, advancing on us_tick; wraps to 0. Width = $clog2(PERIOD_US); pulse-width registers the same width.
- frame_start=1 for exactly one clk: the cycle frame_cnt==0 and prescaler==0.
- pwm <= (frame_cnt < cur_pw) each clk: high time = cur_pw*CLK_DIV clks per frame, 1-cycle register latency, glitch-free.
- Target decode every clk: exactly one input high -> target = matching PWx_US. All-zero or multi-hot -> target held, fault set (cleared only by rst).
- Slew FSM, two states:
  - HOLD: cur_pw==target, at_target=1.
  - RAMP: cur_pw!=target, at_target=0.
  - cur_pw updates only on the frame boundary (the cycle frame_start asserts), so a pulse in progress is never altered. On update, cur_pw moves toward target by min(STEP_US, |target-cur_pw|) with no overshoot. Enter HOLD when equal.
- Target change during RAMP retargets at the next boundary; direction may reverse.
- A state change on the same clk as the boundary is used for that boundary's update.
- cur_pw >= PERIOD_US saturates pwm high all frame (legal, no fault).

Decomposition:
- Shared package: state index constants (ST0/ST1/ST2), FSM encoding (HOLD/RAMP), default pulse-width constants, used by all leg instances and the gait machine bench.
- One natural sub-module: mod_us_frame_timer (prescaler + frame counter, outputs us_tick, frame_cnt, frame_start); reusable by other PWM channels.

Test Plan:
(Bench params: CLK_DIV=2, PERIOD_US=50, PW0_US=10, PW1_US=15, PW2_US=25, STEP_US=4.)
- Reset, all inputs 0 except state0=1 -> frame_start every 100 clks; pwm high exactly 20 clks per frame; at_target=1, fault=0.
- state2=1 (others 0) held -> successive frame widths 10,14,18,22,25 us (20,28,36,44,50 clks); at_target rises with the 25-us frame.
- At width 18 heading to 25, switch to state1 -> next frames 15,15 (one step of 3, no overshoot); at_target=1.
- state0=state2=1 for one clk -> fault=1 and stays 1; target unchanged; pwm widths unaffected.
- Assert rst for one clk mid-pulse during ramp -> next cycle pwm=0, frame_cnt=0, cur_pw=10, fault=0, at_target=1.
- Change state on the exact frame_start cycle -> that frame already uses the stepped width; no pulse truncated or stretched.
